// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_serial block.
// UART_RX_FIFO_EN (when defined) selects the 4-entry rx FIFO over the single holding register.
package uart_pkg;

    localparam int RX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    // Clock cycles per serial bit.
    function automatic int uart_divisor(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO, instantiated by uart_serial only when UART_RX_FIFO_EN is defined.
// A push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       valid,
    output logic [7:0] head_data,
    output logic       overrun
);

    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(RX_FIFO_DEPTH);

    logic [7:0]       mem_r [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             overrun_r;

    logic empty_s;
    logic full_s;
    logic pop_s;
    logic push_s;
    logic drop_s;

    // Handshake qualification.
    always_comb begin
        empty_s = (count_r == '0);
        full_s  = (count_r == COUNT_FULL);
        pop_s   = pop && !empty_s;
        push_s  = push && (!full_s || pop_s);
        drop_s  = push && full_s && !pop_s;
    end

    // Storage, pointers, occupancy and the one-cycle overrun pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            overrun_r <= 1'b0;
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            overrun_r <= drop_s;
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign valid     = !empty_s;
    assign head_data = mem_r[rd_ptr_r];
    assign overrun   = overrun_r;

endmodule

// File: rtl/uart_serial.sv
// 8N1 UART with valid/ready byte interfaces on both directions; tx and rx run independently.
// Define UART_RX_FIFO_EN to buffer received bytes in a 4-entry FIFO instead of one register.
module uart_serial
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_overrun,
    output logic       uart_txd,
    input  logic       uart_rxd
);

    localparam int DIV   = uart_divisor(CLOCK_HZ, BAUD);
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(DIV - 2);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    if (DIV < 16) begin : g_div_too_small
        $error("uart_serial: CLOCK_HZ/BAUD must be at least 16");
    end

    // ------------------------------------------------------------------ tx
    tx_state_t        tx_state_r,  tx_state_nx_s;
    logic [CNT_W-1:0] tx_cnt_r,    tx_cnt_nx_s;
    logic [2:0]       tx_bit_r,    tx_bit_nx_s;
    logic [7:0]       tx_shift_r,  tx_shift_nx_s;
    logic             txd_r,       txd_nx_s;
    logic             tx_ready_r,  tx_ready_nx_s;

    // Tx state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            txd_r      <= 1'b1;
            tx_ready_r <= 1'b0;
        end else begin
            tx_state_r <= tx_state_nx_s;
            tx_cnt_r   <= tx_cnt_nx_s;
            tx_bit_r   <= tx_bit_nx_s;
            tx_shift_r <= tx_shift_nx_s;
            txd_r      <= txd_nx_s;
            tx_ready_r <= tx_ready_nx_s;
        end
    end

    // Tx next state. STOP hands back to IDLE one cycle early so tx_ready is
    // already up on the edge that ends the stop bit, giving gapless frames.
    always_comb begin
        tx_state_nx_s = tx_state_r;
        tx_cnt_nx_s   = tx_cnt_r;
        tx_bit_nx_s   = tx_bit_r;
        tx_shift_nx_s = tx_shift_r;
        txd_nx_s      = txd_r;
        tx_ready_nx_s = tx_ready_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (tx_valid && tx_ready_r) begin
                    tx_state_nx_s = TX_START;
                    tx_shift_nx_s = tx_data;
                    tx_cnt_nx_s   = '0;
                    txd_nx_s      = 1'b0;
                    tx_ready_nx_s = 1'b0;
                end else begin
                    txd_nx_s      = 1'b1;
                    tx_ready_nx_s = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_nx_s = TX_DATA;
                    tx_cnt_nx_s   = '0;
                    tx_bit_nx_s   = 3'd0;
                    txd_nx_s      = tx_shift_r[0];
                end else begin
                    tx_cnt_nx_s = tx_cnt_r + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_nx_s = '0;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_nx_s = TX_STOP;
                        txd_nx_s      = 1'b1;
                    end else begin
                        tx_bit_nx_s   = tx_bit_r + 3'd1;
                        tx_shift_nx_s = {1'b0, tx_shift_r[7:1]};
                        txd_nx_s      = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_nx_s = tx_cnt_r + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == STOP_LAST) begin
                    tx_state_nx_s = TX_IDLE;
                    tx_cnt_nx_s   = '0;
                    tx_ready_nx_s = 1'b1;
                end else begin
                    tx_cnt_nx_s = tx_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                tx_state_nx_s = TX_IDLE;
                tx_cnt_nx_s   = '0;
                txd_nx_s      = 1'b1;
                tx_ready_nx_s = 1'b0;
            end
        endcase
    end

    assign uart_txd = txd_r;
    assign tx_ready = tx_ready_r;

    // ------------------------------------------------------------------ rx
    logic             rxd_meta_r;
    logic             rxd_sync_r;
    logic             rxd_prev_r;
    rx_state_t        rx_state_r,  rx_state_nx_s;
    logic [CNT_W-1:0] rx_cnt_r,    rx_cnt_nx_s;
    logic [2:0]       rx_bit_r,    rx_bit_nx_s;
    logic [7:0]       rx_shift_r,  rx_shift_nx_s;
    logic             rx_push_s;
    logic             rx_pop_s;

    // Line synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= uart_rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    // Rx state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_state_r <= rx_state_nx_s;
            rx_cnt_r   <= rx_cnt_nx_s;
            rx_bit_r   <= rx_bit_nx_s;
            rx_shift_r <= rx_shift_nx_s;
        end
    end

    // Rx next state: half a bit to reach mid-start, then whole bits to each mid-bit.
    always_comb begin
        rx_state_nx_s = rx_state_r;
        rx_cnt_nx_s   = rx_cnt_r;
        rx_bit_nx_s   = rx_bit_r;
        rx_shift_nx_s = rx_shift_r;
        rx_push_s     = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (rxd_prev_r && !rxd_sync_r) begin
                    rx_state_nx_s = RX_START;
                    rx_cnt_nx_s   = '0;
                end else begin
                    rx_state_nx_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_nx_s   = '0;
                    rx_bit_nx_s   = 3'd0;
                    rx_state_nx_s = rxd_sync_r ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_nx_s = rx_cnt_r + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_nx_s   = '0;
                    rx_shift_nx_s = {rxd_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_nx_s = RX_STOP;
                    end else begin
                        rx_bit_nx_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_nx_s = rx_cnt_r + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_nx_s = '0;
                    if (rxd_sync_r) begin
                        rx_push_s     = 1'b1;
                        rx_state_nx_s = RX_IDLE;
                    end else begin
                        rx_state_nx_s = RX_WAIT_IDLE;
                    end
                end else begin
                    rx_cnt_nx_s = rx_cnt_r + CNT_W'(1);
                end
            end
            RX_WAIT_IDLE: begin
                if (rxd_sync_r) begin
                    rx_state_nx_s = RX_IDLE;
                end else begin
                    rx_state_nx_s = RX_WAIT_IDLE;
                end
            end
            default: begin
                rx_state_nx_s = RX_IDLE;
                rx_cnt_nx_s   = '0;
            end
        endcase
    end

    assign rx_pop_s = rx_valid && rx_ready;

`ifdef UART_RX_FIFO_EN
    uart_rx_fifo u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push_s),
        .push_data (rx_shift_r),
        .pop       (rx_pop_s),
        .valid     (rx_valid),
        .head_data (rx_data),
        .overrun   (rx_overrun)
    );
`else
    logic       hold_valid_r;
    logic [7:0] hold_data_r;
    logic       hold_ovr_r;

    // Single holding register; a pop in the same cycle frees the slot for the push.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_valid_r <= 1'b0;
            hold_data_r  <= 8'h00;
            hold_ovr_r   <= 1'b0;
        end else begin
            hold_ovr_r <= rx_push_s && hold_valid_r && !rx_pop_s;
            if (rx_push_s && (!hold_valid_r || rx_pop_s)) begin
                hold_valid_r <= 1'b1;
                hold_data_r  <= rx_shift_r;
            end else if (rx_pop_s) begin
                hold_valid_r <= 1'b0;
            end else begin
                hold_valid_r <= hold_valid_r;
            end
        end
    end

    assign rx_valid   = hold_valid_r;
    assign rx_data    = hold_data_r;
    assign rx_overrun = hold_ovr_r;
`endif

endmodule

// File: doc/uart_serial.md
UART_SERIAL -- requirements
Module: uart_serial

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 50_000_000, meaning the clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, meaning the serial bit rate.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is on its posedge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port tx_valid, input, 1 bit: the SoC offers a byte.
REQ-006 SHALL have port tx_ready, output, 1 bit: the block accepts the byte this cycle.
REQ-007 SHALL have port tx_data, input, 8 bits: the byte to send.
REQ-008 SHALL have port rx_valid, output, 1 bit: a received byte is available.
REQ-009 SHALL have port rx_ready, input, 1 bit: the SoC takes the byte.
REQ-010 SHALL have port rx_data, output, 8 bits: the received byte.
REQ-011 SHALL have port rx_overrun, output, 1 bit: one-cycle pulse when a byte is dropped.
REQ-012 SHALL have port uart_txd, output, 1 bit: serial line out, idle high.
REQ-013 SHALL have port uart_rxd, input, 1 bit: serial line in, asynchronous.

Function
REQ-014 SHALL use bit period D = CLOCK_HZ/BAUD (integer division); elaboration fails if D < 16.
REQ-015 SHALL transfer a tx byte only on clock edges where tx_valid && tx_ready.
REQ-016 SHALL send the frame as 8N1: a start bit (0), data bits LSB first, then a stop bit (1); each bit lasts exactly D cycles.
REQ-017 SHALL use tx FSM states IDLE, START, DATA, STOP; tx_ready=1 only in IDLE.
REQ-018 SHALL drive uart_txd low on the edge after acceptance.
REQ-019 SHALL reassert tx_ready exactly 10*D cycles after the accepting edge, so back-to-back frames have no idle gap.
REQ-020 SHALL pass uart_rxd through a 2-flop synchronizer before any use.
REQ-021 SHALL use rx FSM states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-022 SHALL move IDLE->START on a synchronized 1->0 transition of the line.
REQ-023 SHALL re-sample the line D/2 cycles after the start edge: if the line is 1 (false start), return to IDLE; otherwise go to DATA.
REQ-024 SHALL sample the 8 data bits D cycles apart, at mid-bit, LSB first.
REQ-025 SHALL sample the stop bit at mid-bit: if 1, deliver the byte and return to IDLE; if 0 (framing error), discard the byte and go to WAIT_IDLE until the line reads 1.
REQ-026 SHALL assert rx_valid the cycle after the stop sample, and hold rx_data stable while rx_valid && !rx_ready.
REQ-027 SHALL, when a byte completes while the buffer is full and no pop occurs that cycle, drop the new byte, keep the stored data, and pulse rx_overrun for one cycle.
REQ-028 SHALL, when a push and a pop coincide with the buffer full, accept the push without overrun.
REQ-029 SHALL operate tx and rx fully independently, including simultaneous activity.

Reset
REQ-030 SHALL, while reset=0, set uart_txd=1, tx_ready=0, rx_valid=0, rx_overrun=0, both FSMs to IDLE, and the buffer empty.
REQ-031 SHALL drive tx_ready=1 on the first edge after reset deasserts.
REQ-032 SHALL abandon any frame interrupted by reset mid-operation (partial rx discarded; txd high on the next edge) and SHALL NOT resume it.

Configuration
REQ-033 SHALL, with UART_RX_FIFO_EN defined, buffer rx bytes in a 4-entry FIFO; rx_valid = not empty and rx_data = head entry.
REQ-034 SHALL, without UART_RX_FIFO_EN, use a single holding register (full = rx_valid).

Structure
REQ-035 SHALL place tx/rx state enums, the RX_FIFO_DEPTH=4 constant and the divisor function in package uart_pkg.
REQ-036 SHALL implement the FIFO as sub-module uart_rx_fifo, instantiated only under UART_RX_FIFO_EN.

Verification (CLOCK_HZ=1_000_000, BAUD=62_500, so D=16)
REQ-037 SHALL check: send 0xA5 -> uart_txd pattern 0,1,0,1,0,0,1,0,1,1 at 16 cycles/bit; tx_ready high again 160 cycles after the accepting edge.
REQ-038 SHALL check: loopback txd->rxd with bytes 0x00, 0xFF, 0x55 back-to-back, rx_ready=1 -> rx_valid pulses with the same three bytes in order.
REQ-039 SHALL check: a 5-cycle low glitch on rxd -> no rx_valid; the FSM returns to IDLE.
REQ-040 SHALL check: a frame of 0x3C with stop bit 0 -> no rx_valid; a following valid 0x81 is received once the line has idled high.
REQ-041 SHALL check: rx_ready=0 while 2 bytes arrive (5 bytes with UART_RX_FIFO_EN) -> rx_overrun pulses once; rx_data still holds the first byte.
REQ-042 SHALL check: reset pulled low mid-tx-frame -> uart_txd=1 on the next edge and tx_ready=1 on the first edge after release.
